// File: rtl/dewhite_pkg.sv
// Shared definitions for the framed stream whitener/de-whitener pair:
// frame FSM states, LFSR seed and tap positions, and the LFSR step function.
package dewhite_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // Widest LFSR the shared step function supports.
  localparam int LFSR_MAX = 64;

  // Fixed taps besides the MSB; the tx whitener must use the same set.
  localparam int TAP_MID = 4;
  localparam int TAP_LO1 = 1;
  localparam int TAP_LO0 = 0;

  localparam logic [LFSR_MAX-1:0] LFSR_SEED = '1;

  // One LFSR step for a register of width msb+1, carried in a LFSR_MAX-bit
  // container; bits above msb come back as zero.
  function automatic logic [LFSR_MAX-1:0] lfsr_next(input logic [LFSR_MAX-1:0] s,
                                                    input logic [5:0]          msb);
    logic                fb;
    logic [LFSR_MAX-1:0] keep;
    fb   = s[msb] ^ s[TAP_MID] ^ s[TAP_LO1] ^ s[TAP_LO0];
    keep = LFSR_SEED >> (6'd63 - msb);
    return {s[LFSR_MAX-2:0], fb} & keep;
  endfunction

endpackage

// File: rtl/whiten_lfsr.sv
// Per-frame scrambling LFSR: reseeds to all ones on load, steps on adv,
// and exposes the current mask bit. Shared by the tx whitener and rx de-whitener.
module whiten_lfsr
  import dewhite_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic mask
);

  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_MAX-1:0] wide_next;
  logic                unused_hi;

  always_comb wide_next = lfsr_next(LFSR_MAX'(lfsr), 6'(LFSR_W - 1));

  // Upper container bits are always zero by construction.
  assign unused_hi = ^wide_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED[LFSR_W-1:0];
    end else if (load) begin
      lfsr <= LFSR_SEED[LFSR_W-1:0];
    end else if (adv) begin
      lfsr <= wide_next[LFSR_W-1:0];
    end
  end

  assign mask = lfsr[0];

endmodule

// File: rtl/data_dewhitener.sv
// Receive-side framed de-whitener: strips the length header, unscrambles each
// payload word with the per-frame LFSR and marks first/last words with sof/eof.
//
// state   | meaning
// IDLE    | waiting for a header word (sof_i); stray words flagged on err_o
// PAYLOAD | cnt payload words still expected; sof_i here aborts the frame
module data_dewhitener
  import dewhite_pkg::*;
#(
  parameter int W      = 32,
  parameter int LFSR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sof_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] d_o,
  output logic         sof_o,
  output logic         eof_o,
  output logic         err_o
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] hdr_len;
  logic             first_q, first_d;
  logic             accept;
  logic             last;
  logic             emit;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             err_d;
  logic             mask;

  // A header can always be taken in IDLE since it never occupies the output stage.
  assign ready_o = (state_q == IDLE) | ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign hdr_len = d_i[LEN_W-1:0];
  assign last    = (cnt_q == LEN_W'(1));

  whiten_lfsr #(
    .LFSR_W(LFSR_W)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .mask (mask)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    emit      = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      if (sof_i) begin
        // Header, possibly cutting short an open frame; zero length opens nothing.
        err_d     = (state_q == PAYLOAD);
        lfsr_load = 1'b1;
        if (hdr_len == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = PAYLOAD;
          cnt_d   = hdr_len;
          first_d = 1'b1;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        emit     = 1'b1;
        lfsr_adv = 1'b1;
        first_d  = 1'b0;
        cnt_d    = cnt_q - LEN_W'(1);
        if (last) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      d_o     <= '0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      err_o <= err_d;
      if (emit) begin
        valid_o <= 1'b1;
        d_o     <= d_i ^ {W{mask}};
        sof_o   <= first_q;
        eof_o   <= last;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_dewhitener.sv
// Bench for data_dewhitener: frame-level reference model checked every cycle,
// plus literal expectations for the fixed scenarios.
module tb_data_dewhitener;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] d_i = '0;
  logic        ready_o, valid_o, sof_o, eof_o, err_o;
  logic [31:0] d_o;

  always #5 clk = ~clk;

  data_dewhitener #(.W(32), .LFSR_W(16), .LEN_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .sof_i  (sof_i),
    .d_i    (d_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .d_o    (d_o),
    .sof_o  (sof_o),
    .eof_o  (eof_o),
    .err_o  (err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mask bit for the k-th payload word of a frame: step a fresh all-ones
  // x^16+x^5+x^2+x^1 register k times and take bit 0.
  function automatic bit mask_bit(input int k);
    bit [15:0] s = 16'hFFFF;
    for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[4] ^ s[1] ^ s[0]};
    return s[0];
  endfunction

  // Reference model: the output stage as seen by the consumer, plus frame progress.
  bit        started = 0;
  bit        m_valid = 0, m_sof = 0, m_eof = 0, m_err = 0;
  bit [31:0] m_d = '0;
  bit        m_busy = 0, m_first = 0;
  int        m_left = 0, m_idx = 0;
  bit        m_acc;

  typedef struct packed {logic s; logic e; logic [31:0] d;} out_t;
  out_t cap[$];
  int   err_cnt = 0;
  int   ready_mode = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("valid_o", valid_o, m_valid);
      chk("err_o", err_o, m_err);
      chk("ready_o", ready_o, !m_busy || !m_valid || ready_i);
      if (m_valid) begin
        chk("d_o", d_o, m_d);
        chk("sof_o", sof_o, m_sof);
        chk("eof_o", eof_o, m_eof);
      end
      if (rst_n && valid_o && ready_i) cap.push_back('{sof_o, eof_o, d_o});
      if (err_o) err_cnt++;
    end
    if (!rst_n) begin
      m_valid = 0; m_sof = 0; m_eof = 0; m_err = 0; m_d = '0;
      m_busy = 0; m_first = 0; m_left = 0; m_idx = 0;
    end else begin
      m_acc = valid_i && (!m_busy || !m_valid || ready_i);
      m_err = 0;
      if (m_valid && ready_i) m_valid = 0;
      if (m_acc) begin
        if (sof_i) begin
          m_err   = m_busy;
          m_left  = int'(d_i[15:0]);
          m_busy  = (m_left != 0);
          m_idx   = 0;
          m_first = 1;
        end else if (!m_busy) begin
          m_err = 1;
        end else begin
          m_valid = 1;
          m_d     = d_i ^ {32{mask_bit(m_idx)}};
          m_sof   = m_first;
          m_eof   = (m_left == 1);
          m_first = 0;
          m_left--;
          m_idx++;
          if (m_left == 0) m_busy = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       ready_i = 1'($urandom % 2);
      2:       ready_i = 1'b0;
      default: ready_i = 1'b1;
    endcase
  end

  task automatic send(input bit s, input logic [31:0] d);
    bit ok = 0;
    valid_i = 1'b1;
    sof_i   = s;
    d_i     = d;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (ready_o) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] exp1 [4];
  logic [31:0] orig [37];
  int          n, m, r;

  initial begin
    exp1 = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    @(posedge clk);
    #1;
    started = 1;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_d_o", d_o, 0);
    chk("rst_sof_eof", {sof_o, eof_o}, 0);
    chk("rst_err_o", err_o, 0);
    @(posedge clk);
    #1;

    // Known frame of zeros exposes the raw mask sequence.
    cap.delete();
    send(1, {16'h5A5A, 16'd4});
    repeat (4) send(0, 32'h0);
    idle(4);
    chk("t1_count", cap.size(), 4);
    if (cap.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_data", cap[k].d, exp1[k]);
        chk("t1_sof", cap[k].s, k == 0);
        chk("t1_eof", cap[k].e, k == 3);
      end
    end

    // Round trip through a bench-side whitener.
    cap.delete();
    foreach (orig[k]) orig[k] = $urandom;
    send(1, {16'($urandom), 16'd37});
    for (int k = 0; k < 37; k++) send(0, orig[k] ^ {32{mask_bit(k)}});
    idle(4);
    chk("t2_count", cap.size(), 37);
    if (cap.size() == 37) begin
      for (int k = 0; k < 37; k++) chk("t2_data", cap[k].d, orig[k]);
      chk("t2_sof", cap[0].s, 1);
      chk("t2_eof", cap[36].e, 1);
    end

    // Random traffic under backpressure, including strays, empty frames and aborts.
    ready_mode = 1;
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom % 10);
      if (r == 0) begin
        send(0, $urandom);
      end else begin
        n = int'($urandom % 6);
        m = (r == 1 && n > 1) ? n - 1 : n;
        send(1, {16'($urandom), 16'(n)});
        for (int k = 0; k < m; k++) begin
          send(0, $urandom);
          if ($urandom % 4 == 0) idle(1);
        end
      end
    end
    send(1, {16'h0, 16'd1});
    send(0, $urandom);
    ready_mode = 0;
    idle(4);

    // Abort by a new header mid-frame.
    err_cnt = 0;
    cap.delete();
    send(1, {16'h0, 16'd3});
    send(0, $urandom);
    send(0, $urandom);
    send(1, {16'h0, 16'd1});
    send(0, 32'h0);
    idle(4);
    chk("t4_err_pulses", err_cnt, 1);
    chk("t4_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("t4_first_sof", cap[0].s, 1);
      chk("t4_aborted_no_eof", cap[1].e, 0);
      chk("t4_data", cap[2].d, 32'hFFFF_FFFF);
      chk("t4_sof_eof", {cap[2].s, cap[2].e}, 2'b11);
    end

    // Stray word in IDLE, then an empty frame.
    err_cnt = 0;
    cap.delete();
    send(0, 32'h1234_5678);
    idle(3);
    chk("t5_stray_err", err_cnt, 1);
    chk("t5_stray_out", cap.size(), 0);
    err_cnt = 0;
    send(1, {16'hFFFF, 16'd0});
    idle(3);
    chk("t5_empty_err", err_cnt, 0);
    chk("t5_empty_out", cap.size(), 0);

    // Reset mid-frame with a word held in the output stage.
    ready_mode = 2;
    ready_i    = 1'b0;
    send(1, {16'h0, 16'd5});
    send(0, 32'hDEAD_BEEF);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid_o", valid_o, 0);
    chk("t6_d_o", d_o, 0);
    chk("t6_sof_eof", {sof_o, eof_o}, 0);
    chk("t6_err_o", err_o, 0);
    @(posedge clk);
    #1;
    ready_mode = 0;
    ready_i    = 1'b1;
    cap.delete();
    send(1, {16'h0, 16'd1});
    send(0, 32'h0);
    idle(3);
    chk("t6_count", cap.size(), 1);
    if (cap.size() == 1) begin
      chk("t6_data", cap[0].d, 32'hFFFF_FFFF);
      chk("t6_sof_eof_new", {cap[0].s, cap[0].e}, 2'b11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
